// File: rtl/dyna_tx_arbiter_if.sv
// Request/grant and UART register-port bundle between requesters, the TX
// arbiter and the UART_Dynamixel register file.
interface dyna_tx_arbiter_if;
    logic [1:0]  req;
    logic [63:0] req_word0;
    logic [63:0] req_word1;
    logic [1:0]  req_ack;
    logic [1:0]  done;
    logic        done_err;
    logic        busy;
    logic [7:0]  err_count;
    logic        dyn_write_en;
    logic        dyn_read_en;
    logic [2:0]  dyn_rw_ad;
    logic [31:0] dyn_write_data;
    logic [31:0] dyn_read_data;

    // Requesters plus the UART register file: drive requests and read data.
    modport master (
        output req, req_word0, req_word1, dyn_read_data,
        input  req_ack, done, done_err, busy, err_count,
        input  dyn_write_en, dyn_read_en, dyn_rw_ad, dyn_write_data
    );

    // The arbiter/sequencer itself.
    modport slave (
        input  req, req_word0, req_word1, dyn_read_data,
        output req_ack, done, done_err, busy, err_count,
        output dyn_write_en, dyn_read_en, dyn_rw_ad, dyn_write_data
    );
endinterface

// File: rtl/dyna_tx_arbiter.sv
// Two-way round-robin arbiter that runs the UART_Dynamixel TX register
// sequence (word0, word1, start, poll, clear) for the granted requester.
module dyna_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    dyna_tx_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR0, S_WR1, S_START, S_POLL, S_CLEAR
    } state_t;

    localparam logic [2:0]  AD_WORD0  = 3'b101;
    localparam logic [2:0]  AD_WORD1  = 3'b110;
    localparam logic [2:0]  AD_CTRL   = 3'b100;
    localparam logic [15:0] POLL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_err_flag;
    logic [31:0] r_word0;
    logic [31:0] r_word1;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_err_count;

    logic [31:0] w_req_word0 [2];
    logic [31:0] w_req_word1 [2];
    logic        w_grant_valid;
    logic        w_grant_idx;
    logic        w_poll_done;
    logic        w_poll_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign w_req_word0[gi] = bus.req_word0[32*gi +: 32];
            assign w_req_word1[gi] = bus.req_word1[32*gi +: 32];
        end
    endgenerate

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant_idx    = (bus.req == 2'b11) ? ~r_last_grant : bus.req[1];
    assign w_grant_valid  = (r_state == S_IDLE) && (|bus.req) && !reset;
    assign w_poll_done    = (bus.dyn_read_data == 32'd1);
    assign w_poll_timeout = (r_poll_cnt == POLL_LAST);

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.err_count = r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_err_flag   <= 1'b0;
            r_word0      <= '0;
            r_word1      <= '0;
            r_poll_cnt   <= '0;
            r_err_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_valid) begin
                r_word0      <= w_req_word0[w_grant_idx];
                r_word1      <= w_req_word1[w_grant_idx];
                r_owner      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == S_START) begin
                r_poll_cnt <= '0;
            end
            // A done read in the final poll cycle still counts as success.
            if (r_state == S_POLL) begin
                if (w_poll_done) begin
                    r_err_flag <= 1'b0;
                end else if (w_poll_timeout) begin
                    r_err_flag <= 1'b1;
                end else begin
                    r_poll_cnt <= r_poll_cnt + 16'd1;
                end
            end
            if (r_state == S_CLEAR && r_err_flag && r_err_count != 8'hff) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        bus.req_ack        = 2'b00;
        bus.done           = 2'b00;
        bus.done_err       = 1'b0;
        bus.dyn_write_en   = 1'b0;
        bus.dyn_read_en    = 1'b0;
        bus.dyn_rw_ad      = 3'b000;
        bus.dyn_write_data = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    bus.req_ack[w_grant_idx] = 1'b1;
                    w_state_next             = S_WR0;
                end
            end
            S_WR0: begin
                bus.dyn_write_en   = 1'b1;
                bus.dyn_rw_ad      = AD_WORD0;
                bus.dyn_write_data = r_word0;
                w_state_next       = S_WR1;
            end
            S_WR1: begin
                bus.dyn_write_en   = 1'b1;
                bus.dyn_rw_ad      = AD_WORD1;
                bus.dyn_write_data = r_word1;
                w_state_next       = S_START;
            end
            S_START: begin
                bus.dyn_write_en   = 1'b1;
                bus.dyn_rw_ad      = AD_CTRL;
                bus.dyn_write_data = 32'd1;
                w_state_next       = S_POLL;
            end
            S_POLL: begin
                bus.dyn_read_en = 1'b1;
                bus.dyn_rw_ad   = AD_CTRL;
                if (w_poll_done || w_poll_timeout) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.dyn_write_en     = 1'b1;
                bus.dyn_rw_ad        = AD_CTRL;
                bus.done[r_owner]    = 1'b1;
                bus.done_err         = r_err_flag;
                w_state_next         = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dyna_tx_arbiter.sv
// Cycle-accurate scoreboard bench for dyna_tx_arbiter: every cycle's outputs
// are compared against an expectation queued when the stimulus is applied.
module tb_dyna_tx_arbiter;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dyna_tx_arbiter_if bus ();

    dyna_tx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // UART model: read data is 1 on poll number uart_done_on (0 = never);
    // otherwise a value with bit 0 set that must not be taken as done.
    int          uart_done_on = 0;
    logic [15:0] uart_polls;
    always @(posedge clk) begin
        if (reset || (bus.dyn_write_en && bus.dyn_rw_ad == 3'b100 && bus.dyn_write_data == 32'd1))
            uart_polls <= '0;
        else if (bus.dyn_read_en)
            uart_polls <= uart_polls + 16'd1;
    end
    always_comb begin
        bus.dyn_read_data = 32'h0001_0001;
        if (uart_done_on != 0 && bus.dyn_read_en && int'(uart_polls) == uart_done_on - 1)
            bus.dyn_read_data = 32'd1;
    end

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  done;
        logic        derr;
        logic        busy;
        logic        we;
        logic        re;
        logic [2:0]  ad;
        logic [31:0] wd;
        logic [7:0]  errc;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_errc = 0;

    function automatic obs_t idle_vec();
        obs_t v;
        v = '0;
        v.errc = 8'(exp_errc);
        return v;
    endfunction

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(idle_vec());
    endtask

    task automatic push_prefix(input bit owner, input logic [31:0] w0, input logic [31:0] w1,
                               input int polls);
        obs_t v;
        v = idle_vec(); v.ack[owner] = 1'b1; exp_q.push_back(v);
        v = idle_vec(); v.busy = 1'b1; v.we = 1'b1; v.ad = 3'b101; v.wd = w0; exp_q.push_back(v);
        v = idle_vec(); v.busy = 1'b1; v.we = 1'b1; v.ad = 3'b110; v.wd = w1; exp_q.push_back(v);
        v = idle_vec(); v.busy = 1'b1; v.we = 1'b1; v.ad = 3'b100; v.wd = 32'd1; exp_q.push_back(v);
        repeat (polls) begin
            v = idle_vec(); v.busy = 1'b1; v.re = 1'b1; v.ad = 3'b100; exp_q.push_back(v);
        end
    endtask

    task automatic push_xfer(input bit owner, input logic [31:0] w0, input logic [31:0] w1,
                             input int polls, input bit err);
        obs_t v;
        push_prefix(owner, w0, w1, polls);
        v = idle_vec(); v.busy = 1'b1; v.we = 1'b1; v.ad = 3'b100;
        v.done[owner] = 1'b1; v.derr = err;
        exp_q.push_back(v);
        if (err && exp_errc < 255) exp_errc++;
    endtask

    task automatic run(input int n, input string tag);
        obs_t obs;
        obs_t exp;
        repeat (n) begin
            @(negedge clk); #1;
            obs = '{bus.req_ack, bus.done, bus.done_err, bus.busy, bus.dyn_write_en,
                    bus.dyn_read_en, bus.dyn_rw_ad, bus.dyn_write_data, bus.err_count};
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL %s: observed %h with no expectation queued", tag, obs);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                checks++;
                assert (obs === exp) else begin
                    errors++;
                    $error("FAIL %s: observed %h expected %h", tag, obs, exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.req       = 2'b00;
        bus.req_word0 = '0;
        bus.req_word1 = '0;
        repeat (2) @(posedge clk);
        #1;
        push_idle(1);
        run(1, "reset_state");
        reset = 1'b0;

        // Tie from reset: grants 0,1,0,1 back to back, done on first poll.
        uart_done_on  = 1;
        bus.req_word0 = {32'h1111_0001, 32'h0000_0a00};
        bus.req_word1 = {32'h1111_0002, 32'h0000_0b00};
        bus.req       = 2'b11;
        push_xfer(1'b0, 32'h0000_0a00, 32'h0000_0b00, 1, 1'b0);
        push_xfer(1'b1, 32'h1111_0001, 32'h1111_0002, 1, 1'b0);
        push_xfer(1'b0, 32'h0000_0a00, 32'h0000_0b00, 1, 1'b0);
        push_xfer(1'b1, 32'h1111_0001, 32'h1111_0002, 1, 1'b0);
        run(19, "tie");
        bus.req = 2'b00;
        run(5, "tie");
        push_idle(1);
        run(1, "tie_idle");

        // Single transfer, done on 3rd poll; words scrambled after the ack.
        uart_done_on  = 3;
        bus.req_word0 = {32'hdead_beef, 32'h0002_04fe};
        bus.req_word1 = {32'hcafe_f00d, 32'h0000_012b};
        bus.req       = 2'b01;
        push_xfer(1'b0, 32'h0002_04fe, 32'h0000_012b, 3, 1'b0);
        run(1, "single_ack");
        bus.req       = 2'b00;
        bus.req_word0 = 64'hffff_ffff_ffff_ffff;
        bus.req_word1 = 64'h5555_5555_5555_5555;
        run(7, "single");
        push_idle(1);
        run(1, "single_idle");

        // Done read on the same cycle the timeout would fire.
        uart_done_on  = TMO;
        bus.req_word0 = {32'h0, 32'h0000_00c1};
        bus.req_word1 = {32'h0, 32'h0000_00c2};
        bus.req       = 2'b01;
        push_xfer(1'b0, 32'h0000_00c1, 32'h0000_00c2, TMO, 1'b0);
        run(1, "collide_ack");
        bus.req = 2'b00;
        run(TMO + 4, "collide");
        push_idle(1);
        run(1, "collide_idle");

        // Repeated timeouts: err_count climbs then saturates at 255.
        uart_done_on = 0;
        for (int k = 0; k < 256; k++) begin
            bus.req_word0 = {32'h0, 32'(k)};
            bus.req_word1 = {32'h0, 32'(k) ^ 32'h00ff_0000};
            bus.req       = 2'b01;
            push_xfer(1'b0, 32'(k), 32'(k) ^ 32'h00ff_0000, TMO, 1'b1);
            run(1, "timeout_ack");
            bus.req = 2'b00;
            run(TMO + 4, "timeout");
        end
        push_idle(1);
        run(1, "timeout_idle");
        checks++;
        assert (bus.err_count === 8'd255) else begin
            errors++;
            $error("FAIL err_count_sat: observed %0d expected 255", bus.err_count);
        end

        // Reset during POLL: no CLEAR, no done; pending req=10 granted after release.
        bus.req_word0 = {32'h2222_0001, 32'h0000_0d00};
        bus.req_word1 = {32'h2222_0002, 32'h0000_0e00};
        bus.req       = 2'b01;
        push_prefix(1'b0, 32'h0000_0d00, 32'h0000_0e00, 2);
        run(1, "rst_mid_ack");
        bus.req = 2'b00;
        run(4, "rst_mid");
        reset   = 1'b1;
        bus.req = 2'b10;
        run(1, "rst_mid_poll");
        exp_errc = 0;
        push_idle(1);
        run(1, "rst_mid_idle");
        reset        = 1'b0;
        uart_done_on = 1;
        push_xfer(1'b1, 32'h2222_0001, 32'h2222_0002, 1, 1'b0);
        run(1, "post_reset_ack");
        bus.req = 2'b00;
        run(5, "post_reset");
        push_idle(1);
        run(1, "post_reset_idle");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL leftover: observed %0d queued expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
